avsd_sar_adc_ctrl: RTL and testbench

//  Successive-approximation ADC controller: the analog-to-digital counterpart of the 10-bit avsddac.

---
 rtl/avsd_adc_pkg.sv | 19 +
 rtl/avsd_sar_adc_ctrl_if.sv | 25 ++
 rtl/avsd_cycle_timer.sv | 28 ++
 rtl/avsd_sar_adc_ctrl.sv | 129 ++++++++++++
 tb/tb_avsd_sar_adc_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/avsd_adc_pkg.sv
// Shared types and constants for the SAR ADC controller.
// Result width tracks the avsddac D input.
package avsd_adc_pkg;

  localparam int ADC_NBITS = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/avsd_sar_adc_ctrl_if.sv
// Core/analog-facing bundle of the SAR ADC controller.
// master = core logic plus comparator, slave = controller.
interface avsd_sar_adc_ctrl_if
  import avsd_adc_pkg::*;
#(
  parameter int NBITS = ADC_NBITS
);
  logic             start;
  logic             cmp;
  logic             sample_en;
  logic [NBITS-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] dout;

  modport master (
    output start, cmp,
    input  sample_en, dac_code, busy, done, dout
  );

  modport slave (
    input  start, cmp,
    output sample_en, dac_code, busy, done, dout
  );
endinterface

// File: rtl/avsd_cycle_timer.sv
// Loadable down-counter with a zero flag.
// Stops at zero; load wins over counting.
module avsd_cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/avsd_sar_adc_ctrl.sv
// SAR ADC controller: sample/hold, binary search over the DAC
// code with an external comparator, start/done result handshake.
module avsd_sar_adc_ctrl
  import avsd_adc_pkg::*;
#(
  parameter int NBITS         = ADC_NBITS,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic          CLK,
  input logic          reset,
  avsd_sar_adc_ctrl_if.slave bus
);
  localparam int IW = $clog2(NBITS);
  localparam int TW =
    $clog2(max2(SAMPLE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [TW-1:0] SAMP_LD =
    TW'(SAMPLE_CYCLES - 1);
  localparam logic [TW-1:0] SETL_LD =
    TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [NBITS-1:0] MSB =
    {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [IW-1:0] TOP = IW'(NBITS - 1);
  localparam state_e NXT =
    (SETTLE_CYCLES > 0) ? SETTLE : COMPARE;

  state_e           state_q;
  logic             sample_en_q;
  logic             busy_q;
  logic             done_q;
  logic [NBITS-1:0] dac_q;
  logic [NBITS-1:0] dout_q;
  logic [IW-1:0]    bit_q;
  logic [NBITS-1:0] sar_d;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;

  // Trial result: resolve bit i, then arm bit i-1.
  always_comb begin
    sar_d = dac_q;
    if (!bus.cmp) sar_d[bit_q] = 1'b0;
    if (bit_q != '0) sar_d[bit_q - IW'(1)] = 1'b1;
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE, DONE: begin
        tmr_load = bus.start;
        tmr_val  = SAMP_LD;
      end
      SAMPLE: begin
        tmr_load = tmr_zero && (SETTLE_CYCLES > 0);
        tmr_val  = SETL_LD;
      end
      COMPARE: begin
        tmr_load = (bit_q != '0) && (SETTLE_CYCLES > 0);
        tmr_val  = SETL_LD;
      end
      default: ;
    endcase
  end

  avsd_cycle_timer #(.W(TW)) u_timer (
    .clk    (CLK),
    .reset  (reset),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dac_q       <= '0;
      dout_q      <= '0;
      bit_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q     <= SAMPLE;
            sample_en_q <= 1'b1;
            busy_q      <= 1'b1;
            dac_q       <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        SAMPLE: begin
          if (tmr_zero) begin
            state_q     <= NXT;
            sample_en_q <= 1'b0;
            bit_q       <= TOP;
            dac_q       <= MSB;
          end
        end
        SETTLE: begin
          if (tmr_zero) state_q <= COMPARE;
        end
        COMPARE: begin
          dac_q <= sar_d;
          if (bit_q != '0) begin
            bit_q   <= bit_q - IW'(1);
            state_q <= NXT;
          end else begin
            state_q <= DONE;
            dout_q  <= sar_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sample_en = sample_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dac_code  = dac_q;
  assign bus.dout      = dout_q;
endmodule

// File: tb/tb_avsd_sar_adc_ctrl.sv
// Directed bench for avsd_sar_adc_ctrl: default build plus
// a fast build (SAMPLE_CYCLES=1, SETTLE_CYCLES=0).
module tb_avsd_sar_adc_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] vin_a, vin_b;
  int         checks = 0;
  int         errors = 0;

  logic [9:0] dac_tr [0:200];
  logic       se_tr  [0:200];
  logic       bz_tr  [0:200];

  always #5 clk = ~clk;

  avsd_sar_adc_ctrl_if #(.NBITS(10)) a ();
  avsd_sar_adc_ctrl_if #(.NBITS(10)) b ();

  assign a.cmp = (vin_a >= a.dac_code);
  assign b.cmp = (vin_b >= b.dac_code);

  avsd_sar_adc_ctrl #(
    .NBITS(10), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)
  ) dut_a (
    .CLK(clk), .reset(reset), .bus(a)
  );

  avsd_sar_adc_ctrl #(
    .NBITS(10), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)
  ) dut_b (
    .CLK(clk), .reset(reset), .bus(b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Start at this negedge, wait for done; n = cycles to done.
  task automatic conv(input bit w, input logic [9:0] vin,
                      input bit hold, input int pulse_at,
                      output logic [9:0] res, output int n);
    logic dn;
    if (!w) begin vin_a = vin; a.start = 1'b1; end
    else    begin vin_b = vin; b.start = 1'b1; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!hold) begin
        if (!w) a.start = (n == pulse_at);
        else    b.start = (n == pulse_at);
      end
      if (!w) begin
        dac_tr[n] = a.dac_code;
        se_tr[n]  = a.sample_en;
        bz_tr[n]  = a.busy;
      end
      dn = w ? b.done : a.done;
    end while (!dn && n < 200);
    res = w ? b.dout : a.dout;
  endtask

  logic [9:0] r;
  int         lat;
  bit         saw_done;
  logic [9:0] v;

  initial begin
    reset = 1'b1;
    a.start = 1'b0; b.start = 1'b0;
    vin_a = '0; vin_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_a", {a.sample_en, a.busy, a.done,
                    a.dac_code, a.dout}, 0);
    check("rst_b", {b.sample_en, b.busy, b.done,
                    b.dac_code, b.dout}, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", {a.sample_en, a.busy, a.done,
                     a.dac_code, a.dout}, 0);
    end

    conv(0, 10'h2AA, 0, -1, r, lat);
    check("lat_2aa", lat, 35);
    check("dout_2aa", r, 10'h2AA);
    check("dac_done", a.dac_code, 10'h2AA);
    check("busy_n1", bz_tr[1], 1);
    check("se_n4", se_tr[4], 1);
    check("se_n5", se_tr[5], 0);
    check("dac_n4", dac_tr[4], 10'h000);
    check("dac_n5", dac_tr[5], 10'h200);
    check("dac_n8", dac_tr[8], 10'h300);
    check("dac_n11", dac_tr[11], 10'h280);
    check("dac_n14", dac_tr[14], 10'h2C0);
    check("busy_n34", bz_tr[34], 1);

    conv(0, 10'h000, 0, 10, r, lat);
    check("lat_0", lat, 35);
    check("dout_0", r, 10'h000);
    @(negedge clk);
    check("done_pulse", a.done, 0);
    check("no_queue", a.busy, 0);
    check("dac_hold", a.dac_code, 10'h000);
    conv(0, 10'h3FF, 0, -1, r, lat);
    check("dout_3ff", r, 10'h3FF);
    conv(0, 10'h200, 0, -1, r, lat);
    check("dout_200", r, 10'h200);
    @(negedge clk);

    for (int k = 1; k <= 3; k++) begin
      conv(0, 10'(k), 1, -1, r, lat);
      check("bb_lat", lat, 35);
      check("bb_dout", r, 32'(k));
    end
    a.start = 1'b0;
    @(negedge clk);
    check("bb_end_done", a.done, 0);
    check("bb_end_busy", a.busy, 0);

    vin_a = 10'h2AA;
    a.start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      a.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid", {a.sample_en, a.busy, a.done,
                      a.dac_code, a.dout}, 0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (a.done || a.busy) saw_done = 1'b1;
    end
    check("rst_abort", saw_done, 0);
    conv(0, 10'h155, 0, -1, r, lat);
    check("post_rst_lat", lat, 35);
    check("post_rst_dout", r, 10'h155);
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      v = 10'($urandom_range(0, 1023));
      conv(1, v, 0, -1, r, lat);
      check("fast_lat", lat, 12);
      check("fast_dout", r, v);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
